// File: rtl/qam_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qam_sched_pkg
// Purpose  : Shared types and helpers for the QAM symbol scheduler: mode
//            encodings, FSM state type, bits-per-symbol / symbol-mask helpers
//            and the PRBS-7 scrambler constants.
// Revision : 1.0 - initial release
// ============================================================================
package qam_sched_pkg;

    localparam logic [1:0] MODE_QPSK  = 2'b00;
    localparam logic [1:0] MODE_16QAM = 2'b01;
    localparam logic [1:0] MODE_64QAM = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    // PRBS-7, x^7 + x^6 + 1: feedback is the XOR of the two top stages.
    localparam logic [6:0] PRBS_SEED = 7'h7F;
    localparam logic [6:0] PRBS_TAPS = 7'b110_0000;

    function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
        case (mode)
            MODE_16QAM: bits_per_sym = 3'd4;
            MODE_64QAM: bits_per_sym = 3'd6;
            default:    bits_per_sym = 3'd2;
        endcase
    endfunction

    function automatic logic [5:0] sym_mask(input logic [2:0] k);
        case (k)
            3'd2:    sym_mask = 6'h03;
            3'd4:    sym_mask = 6'h0F;
            default: sym_mask = 6'h3F;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/qam_rate_tick.sv
`default_nettype none
// ============================================================================
// Module   : qam_rate_tick
// Purpose  : Symbol-rate divider. Counts 0..i_rate_div while enabled and
//            pulses o_tick on the terminal count (every cycle when 0).
// Ports    : ACLK/ARESETN   clock, async active-low reset
//            i_en           run enable; counter held at 0 when low
//            i_rate_div     symbol period minus 1 (live)
//            o_tick         one-cycle symbol tick
// Revision : 1.0 - initial release
// ============================================================================
module qam_rate_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_rate_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // ">=" so that lowering rate_div below the current count ticks at once
    // instead of wrapping through the full counter range.
    assign o_tick = i_en && (r_cnt >= i_rate_div);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qam_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qam_symbol_scheduler
// Purpose  : Unpacks AXI-Stream payload words LSB-first into k-bit QAM
//            symbols (k = 2/4/6), prepends a programmable preamble and issues
//            symbols to the mapper at the programmed rate over valid/ready.
// Ports    : ACLK/ARESETN          clock, async active-low reset
//            cfg_*                 enable, mode, rate divider, preamble setup
//            s_axis_t*             payload stream in
//            sym_*                 symbol stream out (data/valid/ready/flags)
//            busy, cfg_err         status; cfg_err is sticky
//            underrun_cnt          saturating count of starved payload ticks
// Options  : QAM_SCRAMBLER_EN - XOR payload bits with PRBS-7 on extraction
// Revision : 1.0 - initial release
// ============================================================================
module qam_symbol_scheduler
    import qam_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_mode,
    input  logic [DIV_WIDTH-1:0]  cfg_rate_div,
    input  logic [7:0]            cfg_preamble_len,
    input  logic [5:0]            cfg_preamble_sym,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [5:0]            sym_data,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic                  sym_last,
    output logic                  sym_is_preamble,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [CNT_WIDTH-1:0]  underrun_cnt
);

    localparam int BUF_W  = DATA_WIDTH + 6;
    localparam int BCNT_W = $clog2(BUF_W + 1);

    state_t              r_state;
    logic [2:0]          r_k;
    logic [7:0]          r_pre_left;
    logic [5:0]          r_pre_sym;
    logic [BUF_W-1:0]    r_buf;
    logic [BCNT_W-1:0]   r_count;
    logic                r_last_loaded;
    logic                r_valid;
    logic [5:0]          r_data;
    logic                r_last;
    logic                r_is_pre;
    logic                r_cfg_err;
    logic [CNT_WIDTH-1:0] r_underrun;

    logic                w_tick;
    logic [BCNT_W-1:0]   w_k_cnt;
    logic                w_load;
    logic [BUF_W-1:0]    w_comb_buf;
    logic [BCNT_W-1:0]   w_comb_cnt;
    logic                w_last_seen;
    logic                w_full_avail;
    logic                w_pay_avail;
    logic                w_can_issue;
    logic                w_pay_issue;
    logic [BCNT_W-1:0]   w_new_cnt;
    logic                w_pay_last;
    logic                w_underrun;
    logic [5:0]          w_pay_sym;
`ifdef QAM_SCRAMBLER_EN
    logic [6:0]          r_lfsr;
    logic [6:0]          w_lfsr_nxt;
    logic [5:0]          w_scr;
    logic                w_fb;
`endif

    qam_rate_tick #(.DIV_WIDTH(DIV_WIDTH)) u_rate_tick (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .i_en       (r_state != ST_IDLE),
        .i_rate_div (cfg_rate_div),
        .o_tick     (w_tick)
    );

    assign w_k_cnt       = BCNT_W'(r_k);
    assign s_axis_tready = (r_state == ST_PAYLOAD) && (r_count < w_k_cnt) && !r_last_loaded;
    assign w_load        = s_axis_tready && s_axis_tvalid;

    // Buffer view including a word being loaded this cycle, so a load and an
    // extract can happen together. Bits above the count are always zero,
    // which provides the zero pad for the final partial symbol.
    assign w_comb_buf   = w_load ? (r_buf | (BUF_W'(s_axis_tdata) << r_count)) : r_buf;
    assign w_comb_cnt   = w_load ? (r_count + BCNT_W'(DATA_WIDTH)) : r_count;
    assign w_last_seen  = r_last_loaded || (w_load && s_axis_tlast);
    assign w_full_avail = (w_comb_cnt >= w_k_cnt);
    assign w_pay_avail  = w_full_avail || (w_last_seen && (w_comb_cnt != '0));

    // Ticks arriving while a symbol is still pending are simply dropped.
    assign w_can_issue  = w_tick && !r_valid;
    assign w_pay_issue  = (r_state == ST_PAYLOAD) && w_can_issue && w_pay_avail;
    assign w_new_cnt    = w_full_avail ? (w_comb_cnt - w_k_cnt) : '0;
    assign w_pay_last   = w_last_seen && (w_new_cnt == '0);
    assign w_underrun   = (r_state == ST_PAYLOAD) && w_can_issue && !w_pay_avail && !r_last_loaded;

    always_comb begin
        w_pay_sym = w_comb_buf[5:0] & sym_mask(r_k);
`ifdef QAM_SCRAMBLER_EN
        // One LFSR step per real payload bit; pad bits are left untouched.
        w_lfsr_nxt = r_lfsr;
        w_scr      = '0;
        w_fb       = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if ((i < int'(r_k)) && (i < int'(w_comb_cnt))) begin
                w_fb       = ^(w_lfsr_nxt & PRBS_TAPS);
                w_scr[i]   = w_fb;
                w_lfsr_nxt = {w_lfsr_nxt[5:0], w_fb};
            end
        end
        w_pay_sym = w_pay_sym ^ w_scr;
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state       <= ST_IDLE;
            r_k           <= 3'd2;
            r_pre_left    <= '0;
            r_pre_sym     <= '0;
            r_buf         <= '0;
            r_count       <= '0;
            r_last_loaded <= 1'b0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_last        <= 1'b0;
            r_is_pre      <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_underrun    <= '0;
`ifdef QAM_SCRAMBLER_EN
            r_lfsr        <= PRBS_SEED;
`endif
        end else begin
            if (r_valid && sym_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (cfg_enable && s_axis_tvalid) begin
                        if (cfg_mode == MODE_RSVD) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_k           <= bits_per_sym(cfg_mode);
                            r_pre_left    <= cfg_preamble_len;
                            r_pre_sym     <= cfg_preamble_sym;
                            r_buf         <= '0;
                            r_count       <= '0;
                            r_last_loaded <= 1'b0;
`ifdef QAM_SCRAMBLER_EN
                            r_lfsr        <= PRBS_SEED;
`endif
                            r_state <= (cfg_preamble_len == 8'd0) ? ST_PAYLOAD : ST_PREAMBLE;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (w_can_issue) begin
                        r_valid    <= 1'b1;
                        r_data     <= r_pre_sym & sym_mask(r_k);
                        r_is_pre   <= 1'b1;
                        r_last     <= 1'b0;
                        r_pre_left <= r_pre_left - 1'b1;
                        if (r_pre_left == 8'd1) begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (w_load && s_axis_tlast) begin
                        r_last_loaded <= 1'b1;
                    end
                    if (w_pay_issue) begin
                        r_valid  <= 1'b1;
                        r_data   <= w_pay_sym;
                        r_is_pre <= 1'b0;
                        r_last   <= w_pay_last;
                        r_buf    <= w_full_avail ? (w_comb_buf >> r_k) : '0;
                        r_count  <= w_new_cnt;
`ifdef QAM_SCRAMBLER_EN
                        r_lfsr   <= w_lfsr_nxt;
`endif
                        if (w_pay_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (w_load) begin
                        r_buf   <= w_comb_buf;
                        r_count <= w_comb_cnt;
                    end
                    if (w_underrun && (r_underrun != {CNT_WIDTH{1'b1}})) begin
                        r_underrun <= r_underrun + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (r_valid && sym_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sym_data        = r_data;
    assign sym_valid       = r_valid;
    assign sym_last        = r_last;
    assign sym_is_preamble = r_is_pre;
    assign busy            = (r_state != ST_IDLE);
    assign cfg_err         = r_cfg_err;
    assign underrun_cnt    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_qam_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_symbol_scheduler
// Purpose  : Self-checking bench for qam_symbol_scheduler. Table of frame
//            vectors with hand-computed symbol sequences, plus directed
//            sequences for rate spacing, stall, underrun, reserved mode and
//            mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qam_symbol_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [15:0] cfg_rate_div = 16'd0;
    logic [7:0]  cfg_preamble_len = 8'd0;
    logic [5:0]  cfg_preamble_sym = 6'd0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [5:0]  sym_data;
    logic        sym_valid;
    logic        sym_ready = 1'b1;
    logic        sym_last;
    logic        sym_is_preamble;
    logic        busy;
    logic        cfg_err;
    logic [15:0] underrun_cnt;

    always #5 ACLK = ~ACLK;

    qam_symbol_scheduler #(
        .DATA_WIDTH(32), .DIV_WIDTH(16), .CNT_WIDTH(16)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_rate_div(cfg_rate_div),
        .cfg_preamble_len(cfg_preamble_len), .cfg_preamble_sym(cfg_preamble_sym),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_last(sym_last), .sym_is_preamble(sym_is_preamble),
        .busy(busy), .cfg_err(cfg_err), .underrun_cnt(underrun_cnt)
    );

    typedef struct {
        logic [1:0]       mode;
        logic [15:0]      div;
        logic [7:0]       pre_len;
        logic [5:0]       pre_sym;
        logic [31:0]      w0;
        logic [31:0]      w1;
        int               nwords;
        bit               drop_en;
        int               stall_at;
        int               nsym;
        logic [23:0][5:0] exp;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [5:0] got_d [$];
    bit         got_l [$];
    bit         got_p [$];
    int         edges [$];
    logic       prev_v = 1'b0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Handshake monitor, sampled mid-cycle.
    always @(negedge ACLK) begin
        if (sym_valid && sym_ready) begin
            got_d.push_back(sym_data);
            got_l.push_back(sym_last);
            got_p.push_back(sym_is_preamble);
        end
        if (sym_valid && !prev_v) edges.push_back(cyc);
        prev_v = sym_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int v, input logic [5:0] s, input int rep);
        for (int r = 0; r < rep; r++) begin
            vecs[v].exp[vecs[v].nsym] = s;
            vecs[v].nsym++;
        end
    endtask

    task automatic clear_mon();
        got_d.delete(); got_l.delete(); got_p.delete(); edges.delete();
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        do begin
            @(negedge ACLK);
            guard++;
        end while (busy && guard < 2000);
        check({name, " frame completes"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input int v);
        int   guard;
        bit   hs;
        logic [5:0] hold;
        @(posedge ACLK); #1;
        clear_mon();
        cfg_mode         = vecs[v].mode;
        cfg_rate_div     = vecs[v].div;
        cfg_preamble_len = vecs[v].pre_len;
        cfg_preamble_sym = vecs[v].pre_sym;
        cfg_enable       = 1'b1;
        sym_ready        = 1'b1;
        for (int w = 0; w < vecs[v].nwords; w++) begin
            s_axis_tdata  = (w == 0) ? vecs[v].w0 : vecs[v].w1;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (w == vecs[v].nwords - 1);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 500) begin
                @(negedge ACLK);
                hs = s_axis_tready;
                @(posedge ACLK); #1;
                guard++;
            end
            check($sformatf("v%0d word%0d accepted", v, w), {31'd0, hs}, 32'd1);
            if (vecs[v].drop_en) cfg_enable = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        if (vecs[v].stall_at >= 0) begin
            guard = 0;
            while ((got_d.size() < vecs[v].stall_at || !sym_valid) && guard < 500) begin
                @(posedge ACLK); #1;
                guard++;
            end
            sym_ready = 1'b0;
            hold = sym_data;
            for (int c = 0; c < 10; c++) begin
                @(negedge ACLK);
                check($sformatf("v%0d stall cycle%0d valid/data held", v, c),
                      {25'd0, sym_valid, sym_data}, {25'd0, 1'b1, hold});
            end
            @(posedge ACLK); #1;
            sym_ready = 1'b1;
        end

        wait_idle($sformatf("v%0d", v));

        check($sformatf("v%0d symbol count", v), got_d.size(), vecs[v].nsym);
        for (int i = 0; i < vecs[v].nsym && i < got_d.size(); i++) begin
            check($sformatf("v%0d sym%0d data", v, i), {26'd0, got_d[i]}, {26'd0, vecs[v].exp[i]});
            check($sformatf("v%0d sym%0d flags(pre,last)", v, i),
                  {30'd0, got_p[i], got_l[i]},
                  {30'd0, (i < int'(vecs[v].pre_len)), (i == vecs[v].nsym - 1)});
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        vecs[0] = '{mode:2'b00, div:16'd0, pre_len:8'd2, pre_sym:6'd3, w0:32'h0000_00E4,
                    w1:32'h0, nwords:1, drop_en:1'b0, stall_at:-1, nsym:0, exp:'0};
        add(0, 6'd3, 2); add(0, 6'd0, 1); add(0, 6'd1, 1); add(0, 6'd2, 1); add(0, 6'd3, 1);
        add(0, 6'd0, 12);
        vecs[1] = '{mode:2'b10, div:16'd1, pre_len:8'd0, pre_sym:6'd0, w0:32'hFFFF_FFFF,
                    w1:32'h0, nwords:1, drop_en:1'b0, stall_at:-1, nsym:0, exp:'0};
        add(1, 6'h3F, 5); add(1, 6'h03, 1);
        vecs[2] = '{mode:2'b10, div:16'd0, pre_len:8'd0, pre_sym:6'd0, w0:32'hFFFF_FFFF,
                    w1:32'h0000_0000, nwords:2, drop_en:1'b0, stall_at:-1, nsym:0, exp:'0};
        add(2, 6'h3F, 5); add(2, 6'h03, 1); add(2, 6'h00, 5);
        vecs[3] = '{mode:2'b01, div:16'd0, pre_len:8'd1, pre_sym:6'h3A, w0:32'h8765_4321,
                    w1:32'h0, nwords:1, drop_en:1'b1, stall_at:-1, nsym:0, exp:'0};
        add(3, 6'h0A, 1);
        for (int s = 1; s <= 8; s++) add(3, 6'(s), 1);
        vecs[4] = '{mode:2'b10, div:16'd2, pre_len:8'd3, pre_sym:6'h15, w0:32'h1234_5678,
                    w1:32'h0, nwords:1, drop_en:1'b0, stall_at:-1, nsym:0, exp:'0};
        add(4, 6'h15, 3); add(4, 6'h38, 1); add(4, 6'h19, 1); add(4, 6'h05, 1);
        add(4, 6'h0D, 1); add(4, 6'h12, 1); add(4, 6'h00, 1);
        vecs[5] = '{mode:2'b00, div:16'd0, pre_len:8'd0, pre_sym:6'd0, w0:32'h8765_4321,
                    w1:32'h0, nwords:1, drop_en:1'b0, stall_at:5, nsym:0, exp:'0};
        for (int n = 1; n <= 8; n++) begin
            add(5, 6'(n & 3), 1);
            add(5, 6'((n >> 2) & 3), 1);
        end
        vecs[6] = '{mode:2'b01, div:16'd3, pre_len:8'd0, pre_sym:6'd0, w0:32'h7654_3210,
                    w1:32'hFEDC_BA98, nwords:2, drop_en:1'b0, stall_at:-1, nsym:0, exp:'0};
        for (int s = 0; s < 16; s++) add(6, 6'(s), 1);

        // ---------------- reset state ----------------
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset outputs", {22'd0, s_axis_tready, sym_data, sym_valid, sym_last,
              sym_is_preamble, busy, cfg_err}, 32'd0);
        check("reset underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("post-reset idle", {29'd0, busy, sym_valid, s_axis_tready}, 32'd0);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < NVEC; v++) run_frame(v);

        // Symbol spacing at rate_div=3 (last frame in the table).
        check("rate edge count", edges.size(), 16);
        for (int i = 1; i < edges.size(); i++)
            check($sformatf("rate edge%0d spacing", i), edges[i] - edges[i-1], 4);

        // ---------------- underrun ----------------
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        clear_mon();
        @(negedge ACLK);
        check("underrun cleared by reset", {16'd0, underrun_cnt}, 32'd0);
        @(posedge ACLK); #1;
        cfg_mode = 2'b00; cfg_rate_div = 16'd0; cfg_preamble_len = 8'd0; cfg_enable = 1'b1;
        s_axis_tdata = 32'h0000_00E4; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        @(posedge ACLK); #1;           // frame starts on this edge
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            check($sformatf("underrun cycle%0d no symbol", c), {31'd0, sym_valid}, 32'd0);
            @(posedge ACLK); #1;
        end
        s_axis_tvalid = 1'b1;
        wait_idle("underrun");
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("underrun_cnt", {16'd0, underrun_cnt}, 32'd5);
        check("underrun frame symbols", got_d.size(), 16);
        if (got_d.size() >= 4)
            check("underrun frame first syms", {8'd0, got_d[0], got_d[1], got_d[2], got_d[3]},
                  {8'd0, 6'd0, 6'd1, 6'd2, 6'd3});

        // ---------------- reserved mode ----------------
        @(posedge ACLK); #1;
        check("cfg_err clear before", {31'd0, cfg_err}, 32'd0);
        cfg_mode = 2'b11; cfg_enable = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
        @(posedge ACLK); #1;
        s_axis_tvalid = 1'b0;
        @(negedge ACLK);
        check("mode11 cfg_err/busy/tready", {29'd0, cfg_err, busy, s_axis_tready}, 32'b100);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("mode11 cfg_err sticky", {30'd0, cfg_err, busy}, 32'b10);

        // ---------------- mid-frame reset ----------------
        @(posedge ACLK); #1;
        cfg_mode = 2'b00; cfg_rate_div = 16'd3; cfg_preamble_len = 8'd4;
        cfg_preamble_sym = 6'd1; s_axis_tdata = 32'hFFFF_FFFF; s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b0;
        repeat (10) @(posedge ACLK);
        @(negedge ACLK);
        check("midframe busy before reset", {31'd0, busy}, 32'd1);
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        #1;
        check("midframe reset outputs same cycle",
              {22'd0, s_axis_tready, sym_data, sym_valid, sym_last, sym_is_preamble, busy, cfg_err},
              32'd0);
        check("midframe reset underrun", {16'd0, underrun_cnt}, 32'd0);
        @(posedge ACLK); #1;
        s_axis_tvalid = 1'b0; cfg_enable = 1'b0;
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("after reset idle", {29'd0, busy, sym_valid, cfg_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
